trace_serializer: RTL and testbench

Upstream producer for `cpu_checker`. Takes one CPU write-back record per handshake and emits its textual trace line as one ASCII character per cycle on `char`, in the exact format the checker parses. The test harness drives the checker from real CPU events, with no hand-written character stimulus.

---
 rtl/trace_pkg.sv | 58 +++++
 rtl/bin2bcd_seq.sv | 58 +++++
 rtl/trace_serializer.sv | 263 ++++++++++++++++++++++++++
 tb/tb_trace_serializer.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared constants, enums and helpers for the trace line serializer.
package trace_pkg;

    // ASCII codes for the fixed punctuation of a trace line
    localparam logic [7:0] ASCII_CARET  = 8'h5E;
    localparam logic [7:0] ASCII_AT     = 8'h40;
    localparam logic [7:0] ASCII_COLON  = 8'h3A;
    localparam logic [7:0] ASCII_DOLLAR = 8'h24;
    localparam logic [7:0] ASCII_STAR   = 8'h2A;
    localparam logic [7:0] ASCII_LT     = 8'h3C;
    localparam logic [7:0] ASCII_EQ     = 8'h3D;
    localparam logic [7:0] ASCII_HASH   = 8'h23;
    localparam logic [7:0] ASCII_SPACE  = 8'h20;
    localparam logic [7:0] ASCII_ZERO   = 8'h30;

    // Record kind encoding carried on in_kind
    localparam logic KIND_REG = 1'b0;
    localparam logic KIND_MEM = 1'b1;

    // Top-level serializer states
    typedef enum logic [1:0] {
        IDLE,
        CONV,
        EMIT
    } state_t;

    // Fields of a line, in the order they are printed
    typedef enum logic [3:0] {
        CARET,
        TIME,
        AT,
        PC,
        COLON,
        SP0,
        TAG,
        TARGET,
        SP1,
        LT,
        EQ,
        SP2,
        DATA,
        HASH
    } field_t;

    // Lowercase hex character for one nibble
    function automatic logic [7:0] hex_char(input logic [3:0] nib);
        if (nib < 4'd10) begin
            return ASCII_ZERO + {4'h0, nib};
        end
        return 8'h57 + {4'h0, nib};
    endfunction

    // Decimal digits needed for a w-bit unsigned value: ceil(w * log10(2))
    function automatic int bcd_digits(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble: one shift-and-adjust step per cycle, W steps.
module bin2bcd_seq
    import trace_pkg::*;
#(
    parameter int W = 16,
    parameter int D = bcd_digits(W)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           start,
    input  logic [W-1:0]   bin,
    output logic           done,
    output logic [4*D-1:0] bcd
);

    localparam int CNT_W = $clog2(W + 1);

    logic [W-1:0]     shift;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic [4*D-1:0]   bcd_adj;

    // Add 3 to every BCD digit that is 5 or more before the next shift
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < D; d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    // done flags the cycle in which the final step is being applied
    assign done = busy && (count == CNT_W'(W - 1));

    // Load on start, then shift the binary MSB into the adjusted BCD each cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            shift <= '0;
            count <= '0;
            busy  <= 1'b0;
            bcd   <= '0;
        end else if (start) begin
            shift <= bin;
            count <= '0;
            busy  <= 1'b1;
            bcd   <= '0;
        end else if (busy) begin
            bcd   <= {bcd_adj[4*D-2:0], shift[W-1]};
            shift <= shift << 1;
            count <= count + CNT_W'(1);
            if (done) begin
                busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/trace_serializer.sv
// Turns one write-back record into its ASCII trace line, one char per cycle.
module trace_serializer
    import trace_pkg::*;
#(
    parameter int TIME_W = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_kind,
    input  logic [TIME_W-1:0] in_time,
    input  logic [31:0]       in_pc,
    input  logic [4:0]        in_reg,
    input  logic [31:0]       in_addr,
    input  logic [31:0]       in_data,
    output logic [7:0]        char,
    output logic              char_valid
);

    localparam int DIGITS = bcd_digits(TIME_W);
    localparam int IDX_W  = (DIGITS > 8) ? $clog2(DIGITS) : 3;

    state_t             state, state_next;
    field_t             field, field_next;
    logic [IDX_W-1:0]   digit_cnt, digit_next;
    logic               time_first, first_next;
    logic [7:0]         char_next;
    logic               char_valid_next;
    logic               latch;
    logic               bcd_start;
    logic               bcd_done;
    logic [4*DIGITS-1:0] bcd_value;

    logic               kind_q;
    logic [31:0]        pc_q;
    logic [4:0]         dest_q;
    logic [31:0]        addr_q;
    logic [31:0]        data_q;

    logic [IDX_W-1:0]   msd_idx;
    logic [IDX_W-1:0]   time_idx;
    logic [3:0]         time_digit;
    logic [1:0]         reg_tens;
    logic [3:0]         reg_ones;
    logic [4:0]         reg_rem;

    bin2bcd_seq #(
        .W (TIME_W)
    ) u_bcd (
        .clk   (clk),
        .reset (reset),
        .start (bcd_start),
        .bin   (in_time),
        .done  (bcd_done),
        .bcd   (bcd_value)
    );

    // Ready only in IDLE and never while reset is asserted
    assign in_ready = (state == IDLE) && !reset;

    // Locate the most significant non-zero decimal digit; zero maps to digit 0
    always_comb begin
        msd_idx = '0;
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_value[4*i +: 4] != 4'h0) begin
                msd_idx = IDX_W'(i);
            end
        end
    end

    // Pick the time digit being printed; the first one skips leading zeros
    always_comb begin
        time_idx   = time_first ? msd_idx : digit_cnt;
        time_digit = 4'h0;
        for (int i = 0; i < DIGITS; i++) begin
            if (IDX_W'(i) == time_idx) begin
                time_digit = bcd_value[4*i +: 4];
            end
        end
    end

    // Split the 0..31 register number into tens and ones
    always_comb begin
        if (dest_q >= 5'd30) begin
            reg_tens = 2'd3;
            reg_rem  = dest_q - 5'd30;
        end else if (dest_q >= 5'd20) begin
            reg_tens = 2'd2;
            reg_rem  = dest_q - 5'd20;
        end else if (dest_q >= 5'd10) begin
            reg_tens = 2'd1;
            reg_rem  = dest_q - 5'd10;
        end else begin
            reg_tens = 2'd0;
            reg_rem  = dest_q;
        end
        reg_ones = reg_rem[3:0];
    end

    // Next-state, field walk and next character
    always_comb begin
        state_next      = state;
        field_next      = field;
        digit_next      = digit_cnt;
        first_next      = time_first;
        char_next       = 8'h00;
        char_valid_next = 1'b0;
        bcd_start       = 1'b0;
        latch           = 1'b0;

        case (state)
            IDLE: begin
                if (in_valid && in_ready) begin
                    bcd_start  = 1'b1;
                    latch      = 1'b1;
                    state_next = CONV;
                end
            end

            CONV: begin
                if (bcd_done) begin
                    state_next      = EMIT;
                    char_next       = ASCII_CARET;
                    char_valid_next = 1'b1;
                    field_next      = TIME;
                    first_next      = 1'b1;
                end
            end

            EMIT: begin
                char_valid_next = 1'b1;
                case (field)
                    TIME: begin
                        char_next = ASCII_ZERO | {4'h0, time_digit};
                        if (time_idx == '0) begin
                            field_next = AT;
                        end else begin
                            digit_next = time_idx - IDX_W'(1);
                            first_next = 1'b0;
                        end
                    end
                    AT: begin
                        char_next  = ASCII_AT;
                        field_next = PC;
                        digit_next = IDX_W'(7);
                    end
                    PC: begin
                        char_next = hex_char(pc_q[{digit_cnt[2:0], 2'b00} +: 4]);
                        if (digit_cnt == '0) begin
                            field_next = COLON;
                        end else begin
                            digit_next = digit_cnt - IDX_W'(1);
                        end
                    end
                    COLON: begin
                        char_next  = ASCII_COLON;
                        field_next = SP0;
                    end
                    SP0: begin
                        char_next  = ASCII_SPACE;
                        field_next = TAG;
                    end
                    TAG: begin
                        field_next = TARGET;
                        if (kind_q == KIND_MEM) begin
                            char_next  = ASCII_STAR;
                            digit_next = IDX_W'(7);
                        end else begin
                            char_next  = ASCII_DOLLAR;
                            digit_next = (dest_q >= 5'd10) ? IDX_W'(1) : IDX_W'(0);
                        end
                    end
                    TARGET: begin
                        if (kind_q == KIND_MEM) begin
                            char_next = hex_char(addr_q[{digit_cnt[2:0], 2'b00} +: 4]);
                        end else if (digit_cnt != '0) begin
                            char_next = ASCII_ZERO | {6'h00, reg_tens};
                        end else begin
                            char_next = ASCII_ZERO | {4'h0, reg_ones};
                        end
                        if (digit_cnt == '0) begin
                            field_next = SP1;
                        end else begin
                            digit_next = digit_cnt - IDX_W'(1);
                        end
                    end
                    SP1: begin
                        char_next  = ASCII_SPACE;
                        field_next = LT;
                    end
                    LT: begin
                        char_next  = ASCII_LT;
                        field_next = EQ;
                    end
                    EQ: begin
                        char_next  = ASCII_EQ;
                        field_next = SP2;
                    end
                    SP2: begin
                        char_next  = ASCII_SPACE;
                        field_next = DATA;
                        digit_next = IDX_W'(7);
                    end
                    DATA: begin
                        char_next = hex_char(data_q[{digit_cnt[2:0], 2'b00} +: 4]);
                        if (digit_cnt == '0) begin
                            field_next = HASH;
                        end else begin
                            digit_next = digit_cnt - IDX_W'(1);
                        end
                    end
                    HASH: begin
                        char_next  = ASCII_HASH;
                        field_next = CARET;
                        state_next = IDLE;
                    end
                    default: begin
                        char_valid_next = 1'b0;
                        field_next      = CARET;
                        state_next      = IDLE;
                    end
                endcase
            end

            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State, field walk, output character and latched record registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            field      <= CARET;
            digit_cnt  <= '0;
            time_first <= 1'b0;
            char       <= 8'h00;
            char_valid <= 1'b0;
            kind_q     <= KIND_REG;
            pc_q       <= '0;
            dest_q     <= '0;
            addr_q     <= '0;
            data_q     <= '0;
        end else begin
            state      <= state_next;
            field      <= field_next;
            digit_cnt  <= digit_next;
            time_first <= first_next;
            char       <= char_next;
            char_valid <= char_valid_next;
            if (latch) begin
                kind_q <= in_kind;
                pc_q   <= in_pc;
                dest_q <= in_reg;
                addr_q <= in_addr;
                data_q <= in_data;
            end
        end
    end

endmodule

// File: tb/tb_trace_serializer.sv
// Directed self-checking bench for trace_serializer with TIME_W = 16.
module tb_trace_serializer;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic        in_kind;
    logic [15:0] in_time;
    logic [31:0] in_pc;
    logic [4:0]  in_reg;
    logic [31:0] in_addr;
    logic [31:0] in_data;
    logic [7:0]  ch;
    logic        ch_valid;

    int assert_count = 0;
    int fail_count   = 0;
    int cyc          = 0;

    trace_serializer #(
        .TIME_W (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_kind    (in_kind),
        .in_time    (in_time),
        .in_pc      (in_pc),
        .in_reg     (in_reg),
        .in_addr    (in_addr),
        .in_data    (in_data),
        .char       (ch),
        .char_valid (ch_valid)
    );

    // 10 ns clock
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Cycle index, sampled #1 after each rising edge
    always @(posedge clk) cyc <= cyc + 1;

    // Hard stop in case a wait is ever left unbounded
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assert_count++;
        assert (observed === expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkLine(input string tag, input string observed, input string expected);
        assert_count++;
        assert (observed == expected) else begin
            fail_count++;
            $error("[TB] FAIL %s: observed '%s' expected '%s'", tag, observed, expected);
        end
    endtask

    // Present one record at the current sample point; handshake happens at the next edge
    task automatic applyStimulus(input logic kind, input logic [15:0] t, input logic [31:0] pc,
                                 input logic [4:0] rg, input logic [31:0] addr, input logic [31:0] data,
                                 input bit hold, output int hs_cyc);
        in_kind  = kind;
        in_time  = t;
        in_pc    = pc;
        in_reg   = rg;
        in_addr  = addr;
        in_data  = data;
        in_valid = 1'b1;
        hs_cyc   = cyc;
        @(posedge clk); #1;
        if (!hold) in_valid = 1'b0;
    endtask

    // Collect one line; returns at the sample point of the '#' cycle
    task automatic captureLine(output string line, output int caret_cyc, output int hash_cyc,
                               output bit gap, output bit ready_in_emit, output bit ready_at_hash);
        int budget;
        line          = "";
        caret_cyc     = -1;
        hash_cyc      = -1;
        gap           = 1'b0;
        ready_in_emit = 1'b0;
        ready_at_hash = 1'b0;
        budget        = 0;
        while (!ch_valid && budget < 100) begin
            @(posedge clk); #1;
            budget++;
        end
        if (!ch_valid) return;
        caret_cyc = cyc;
        while (line.len() < 64) begin
            if (!ch_valid) begin
                gap = 1'b1;
                break;
            end
            line = $sformatf("%s%c", line, ch);
            if (ch == 8'h23) begin
                hash_cyc      = cyc;
                ready_at_hash = in_ready;
                break;
            end
            if (in_ready) ready_in_emit = 1'b1;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        string line;
        int    hs, caret, hash, hash_a, len;
        bit    gap, rdy_emit, rdy_hash, stray;

        reset    = 1'b1;
        in_valid = 1'b0;
        in_kind  = 1'b0;
        in_time  = '0;
        in_pc    = '0;
        in_reg   = '0;
        in_addr  = '0;
        in_data  = '0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_char", ch, 8'h00);
        checkOutput("reset_char_valid", ch_valid, 1'b0);
        checkOutput("reset_in_ready", in_ready, 1'b0);
        reset = 1'b0;
        @(posedge clk); #1;
        checkOutput("post_reset_in_ready", in_ready, 1'b1);

        // Register line, timing of the caret and contiguity
        applyStimulus(1'b0, 16'd1024, 32'h0000_3000, 5'd9, 32'h0, 32'h0, 1'b0, hs);
        checkOutput("conv_in_ready", in_ready, 1'b0);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("reg_line", line, "^1024@00003000: $9 <= 00000000#");
        len = line.len();
        checkOutput("reg_line_len", len, 31);
        checkOutput("reg_caret_latency", caret - hs, 17);
        checkOutput("reg_contiguous", gap, 1'b0);
        checkOutput("reg_ready_in_emit", rdy_emit, 1'b0);
        checkOutput("reg_ready_at_hash", rdy_hash, 1'b1);
        @(posedge clk); #1;
        checkOutput("idle_char_valid", ch_valid, 1'b0);
        checkOutput("idle_char", ch, 8'h00);

        // Memory line with time zero
        applyStimulus(1'b1, 16'd0, 32'h0000_3004, 5'd0, 32'h0000_007c, 32'hdead_beef, 1'b0, hs);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("mem_line", line, "^0@00003004: *0000007c <= deadbeef#");
        len = line.len();
        checkOutput("mem_line_len", len, 35);
        checkOutput("mem_caret_latency", caret - hs, 17);
        @(posedge clk); #1;

        // Largest time and two-digit register
        applyStimulus(1'b0, 16'd65535, 32'h1234_5678, 5'd31, 32'h0, 32'hcafe_f00d, 1'b0, hs);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("max_time_line", line, "^65535@12345678: $31 <= cafef00d#");
        @(posedge clk); #1;

        // Time with an embedded zero and register zero
        applyStimulus(1'b0, 16'd10, 32'h0000_abcd, 5'd0, 32'h0, 32'h0000_000a, 1'b0, hs);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("time10_reg0_line", line, "^10@0000abcd: $0 <= 0000000a#");
        @(posedge clk); #1;

        // Back-to-back: in_valid stays high and switches to the second record during EMIT
        applyStimulus(1'b0, 16'd500, 32'h0000_0040, 5'd12, 32'h0, 32'h0000_ffff, 1'b1, hs);
        in_kind = 1'b1;
        in_time = 16'd7;
        in_pc   = 32'h0000_0100;
        in_reg  = 5'd3;
        in_addr = 32'hffff_fffc;
        in_data = 32'h1234_5678;
        captureLine(line, caret, hash_a, gap, rdy_emit, rdy_hash);
        checkLine("b2b_first_line", line, "^500@00000040: $12 <= 0000ffff#");
        checkOutput("b2b_first_ready_in_emit", rdy_emit, 1'b0);
        checkOutput("b2b_ready_at_hash", rdy_hash, 1'b1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("b2b_second_accepted", in_ready, 1'b0);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("b2b_second_line", line, "^7@00000100: *fffffffc <= 12345678#");
        checkOutput("b2b_second_caret", caret - hash_a, 17);
        @(posedge clk); #1;

        // Reset on the 12th character of a line
        applyStimulus(1'b0, 16'd300, 32'h0000_2000, 5'd5, 32'h0, 32'h1111_1111, 1'b0, hs);
        for (int i = 0; i < 40 && !ch_valid; i++) begin
            @(posedge clk); #1;
        end
        checkOutput("rst_line_started", ch, 8'h5e);
        repeat (11) @(posedge clk);
        #1;
        checkOutput("rst_char12", ch, 8'h30);
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("rst_char_valid", ch_valid, 1'b0);
        checkOutput("rst_char", ch, 8'h00);
        reset = 1'b0;
        stray = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            if (ch_valid) stray = 1'b1;
        end
        checkOutput("rst_no_partial_line", stray, 1'b0);
        checkOutput("rst_in_ready", in_ready, 1'b1);

        applyStimulus(1'b0, 16'd42, 32'hffff_ffff, 5'd17, 32'h0, 32'h8000_0001, 1'b0, hs);
        captureLine(line, caret, hash, gap, rdy_emit, rdy_hash);
        checkLine("after_reset_line", line, "^42@ffffffff: $17 <= 80000001#");
        checkOutput("after_reset_caret", caret - hs, 17);
        @(posedge clk); #1;

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
